// File: rtl/cpu_defs_pkg.sv
// Shared CPU encodings: writeback source select, load types, register address width.
package cpu_defs;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction with sign/zero extension and misalignment detect.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module load_align
  import cpu_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext_data,
  output logic              misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rdata[{off, 3'b000} +: 8];
    half_v   = off[1] ? rdata[31:16] : rdata[15:0];
    ext_data = rdata;
    misalign = 1'b0;
    unique case (load_type)
      LD_LB:  ext_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_LBU: ext_data = {{(DATA_W-8){1'b0}}, byte_v};
      LD_LH: begin
        ext_data = {{(DATA_W-16){half_v[15]}}, half_v};
        misalign = off[0];
      end
      LD_LHU: begin
        ext_data = {{(DATA_W-16){1'b0}}, half_v};
        misalign = off[0];
      end
      // LW and every unassigned code behave as a full-word load
      default: misalign = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB register: selects and formats writeback data, drives the regfile write port.
// Latency: 1 cycle from MEM inputs to we/waddr/wdata.
// Backpressure: stall holds all state, flush loads a bubble; no ready handshake.
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = REG_ADDR_W,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_we,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_mem_rdata,
  input  logic [DATA_W-1:0]  in_link_pc,
  input  logic [1:0]         in_wb_sel,
  input  logic [2:0]         in_load_type,
  output logic               we,
  output logic [RADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               wb_valid,
  output logic               misalign_exc,
  output logic [CNT_W-1:0]   instret
);

  logic [DATA_W-1:0]  ld_data;
  logic               ld_misalign;
  logic               is_load;
  logic               mis_nxt;
  logic               we_nxt;
  logic [RADDR_W-1:0] waddr_nxt;
  logic [DATA_W-1:0]  wdata_nxt;
  logic [DATA_W-1:0]  sel_data;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata     (in_mem_rdata),
    .off       (in_alu_result[1:0]),
    .load_type (in_load_type),
    .ext_data  (ld_data),
    .misalign  (ld_misalign)
  );

  always_comb begin
    unique case (in_wb_sel)
      WB_SEL_LOAD: sel_data = ld_data;
      WB_SEL_LINK: sel_data = in_link_pc;
      default:     sel_data = in_alu_result;
    endcase
    is_load = (in_wb_sel == WB_SEL_LOAD);
    mis_nxt = in_valid && is_load && ld_misalign;
    // Any write that is suppressed or targets $0 is zeroed completely so the
    // regfile's same-address bypass can never leak a value for $0.
    we_nxt    = in_valid && in_we && !mis_nxt && (in_waddr != '0);
    waddr_nxt = we_nxt ? in_waddr : '0;
    wdata_nxt = we_nxt ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      wb_valid     <= 1'b0;
      misalign_exc <= 1'b0;
      instret      <= '0;
    end else if (flush) begin
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      wb_valid     <= 1'b0;
      misalign_exc <= 1'b0;
    end else if (!stall) begin
      we           <= we_nxt;
      waddr        <= waddr_nxt;
      wdata        <= wdata_nxt;
      wb_valid     <= in_valid;
      misalign_exc <= mis_nxt;
      if (in_valid) instret <= instret + 1'b1;
    end
  end

endmodule
